// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: registered-PC instruction fetch with one outstanding request, single-slot holding buffer, redirect on consume and flush.
module rv_fetch_unit #(
  parameter int          PC_W      = 16,
  parameter logic [31:0] RESET_VEC = 32'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic [PC_W-1:0] imm_ext,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            fetch_err
);
  typedef enum logic [1:0] {IDLE, WAIT, HALT} state_e;
  localparam logic [PC_W-1:0] RST_PC = RESET_VEC[PC_W-1:0];
  localparam logic [PC_W-1:0] FOUR = PC_W'(4);
  state_e state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic valid_q, valid_d, err_q, err_d, kill_q, kill_d, req_q, req_d;
  logic consume, taken;
  logic [PC_W-1:0] target;
  assign consume = valid_q & ~stall;
  assign taken = jump | (branch & zero);
  assign target = pc_q + imm_ext;
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d = err_q;
    kill_d = kill_q;
    req_d = 1'b0;
    if (flush) begin
      valid_d = 1'b0;
      fetch_pc_d = flush_pc;
      err_d = |flush_pc[1:0];
      // an in-flight response must still be swallowed before fetching resumes
      kill_d = ~imem_rvalid & ((state_q == WAIT) | kill_q);
      state_d = err_d ? HALT : kill_d ? WAIT : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (consume) begin
            valid_d = 1'b0;
            if (taken) fetch_pc_d = target;
          end
          if (consume & taken & |target[1:0]) begin
            err_d = 1'b1;
            state_d = HALT;
          end else if (~valid_q | consume) begin
            req_d = 1'b1;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_d = IDLE;
            kill_d = 1'b0;
            if (!kill_q) begin
              instr_d = imem_rdata;
              pc_d = fetch_pc_q;
              valid_d = 1'b1;
              fetch_pc_d = fetch_pc_q + FOUR;
            end
          end
        end
        HALT: if (imem_rvalid) kill_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fetch_pc_q <= RST_PC;
      pc_q <= RST_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      kill_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q <= err_d;
      kill_q <= kill_d;
      req_q <= req_d;
    end
  end
  assign imem_req = req_q;
  assign imem_addr = fetch_pc_q;
  assign instr = valid_q ? instr_q : NOP_INSTR;
  assign instr_valid = valid_q;
  assign pc = pc_q;
  assign pc_plus4 = pc_q + FOUR;
  assign fetch_err = err_q;
endmodule
